// File: rtl/fb_lsu_pkg.sv
// fb_lsu_pkg: shared constants and helpers for the MEM-stage load/store unit.
// Holds funct3 encodings, FSM state encodings, the captured-request struct
// and the access legality check (funct3 + alignment).
package fb_lsu_pkg;

  localparam int XLEN = 32;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // FSM state encodings
  localparam logic [0:0] FB_LSU_IDLE = 1'b0;
  localparam logic [0:0] FB_LSU_REQ  = 1'b1;

  // Per-access context kept across the bus transfer
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] offset;
  } lsu_req_t;

  // Legal = recognised funct3 for the access direction and naturally aligned.
  // Stores only use 000/001/010, which share encodings with LB/LH/LW.
  function automatic logic lsu_acc_ok(input logic is_load, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic ok;
    case (f3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = ~off[0];
      F3_LW:   ok = (off == 2'b00);
      F3_LBU:  ok = is_load;
      F3_LHU:  ok = is_load & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fb_lsu_ldfmt.sv
// fb_lsu_ldfmt: combinational load-data formatter.
// Ports: rdata_i (bus word), offset_i (byte offset), funct3_i (load type)
//        -> result_o (byte/half selected, sign- or zero-extended to 32 bits).
module fb_lsu_ldfmt
  import fb_lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'b00:   byte_sel = rdata_i[7:0];
      2'b01:   byte_sel = rdata_i[15:8];
      2'b10:   byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // Halfwords are 2-byte aligned, so only offset bit 1 picks the half
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result_o = {24'h0, byte_sel};
      F3_LHU:  result_o = {16'h0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/fb_lsu.sv
// fb_lsu: MEM-stage load/store unit driving a req/ready data-memory bus.
// Ports: EX access (ex_*), pipeline stall, registered bus master (mem_*),
//        load result / store done pulses and error pulses to the trap logic.
module fb_lsu
  import fb_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  output logic            lsu_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            ld_valid,
  output logic [XLEN-1:0] ld_data,
  output logic            st_done,
  output logic            acc_err,
  output logic            bus_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [0:0]      state_q,    state_d;
  logic            req_q,      req_d;
  logic [XLEN-1:0] addr_q,     addr_d;
  logic [3:0]      wstrb_q,    wstrb_d;
  logic [XLEN-1:0] wdata_q,    wdata_d;
  lsu_req_t        ctx_q,      ctx_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic            ld_valid_q, ld_valid_d;
  logic [XLEN-1:0] ld_data_q,  ld_data_d;
  logic            st_done_q,  st_done_d;
  logic            acc_err_q,  acc_err_d;
  logic            bus_err_q,  bus_err_d;

  logic            acc;
  logic            acc_ok;
  logic            accept;
  logic            timeout_hit;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_lanes;
  logic [XLEN-1:0] ld_fmt;

  fb_lsu_ldfmt u_ldfmt (
    .rdata_i  (mem_rdata),
    .offset_i (ctx_q.offset),
    .funct3_i (ctx_q.funct3),
    .result_o (ld_fmt)
  );

  assign acc    = ex_valid & (ex_is_load | ex_is_store);
  assign acc_ok = lsu_acc_ok(ex_is_load, ex_funct3, ex_addr[1:0]);
  assign accept = (state_q == FB_LSU_IDLE) & acc & acc_ok;

  // A ready in the limit cycle takes priority, so the abort also needs ~mem_ready
  assign timeout_hit = (TIMEOUT_CYC > 0) && (cnt_q == CNT_LIMIT) && !mem_ready;

  // Idle: stall only while a legal access is being accepted.
  // Busy: release in the cycle the bus completes so EX advances with it.
  assign lsu_stall = (state_q == FB_LSU_IDLE) ? accept : ~mem_ready;

  // Store lane replication and byte strobes; loads never drive strobes
  always_comb begin
    st_strb  = 4'b1111;
    st_lanes = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << ex_addr[1:0];
        st_lanes = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        st_strb  = ex_addr[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{ex_wdata[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_lanes = ex_wdata;
      end
    endcase
    if (ex_is_load) st_strb = 4'b0000;
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    ctx_d      = ctx_q;
    cnt_d      = cnt_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    st_done_d  = 1'b0;
    acc_err_d  = 1'b0;
    bus_err_d  = 1'b0;

    if (state_q == FB_LSU_IDLE) begin
      if (acc && !acc_ok) begin
        acc_err_d = 1'b1;
      end else if (accept) begin
        state_d      = FB_LSU_REQ;
        req_d        = 1'b1;
        addr_d       = {ex_addr[XLEN-1:2], 2'b00};
        wstrb_d      = st_strb;
        wdata_d      = st_lanes;
        ctx_d.we     = ex_is_store;
        ctx_d.funct3 = ex_funct3;
        ctx_d.offset = ex_addr[1:0];
        cnt_d        = '0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (mem_ready) begin
        state_d = FB_LSU_IDLE;
        req_d   = 1'b0;
        if (ctx_q.we) begin
          st_done_d = 1'b1;
        end else begin
          ld_valid_d = 1'b1;
          ld_data_d  = ld_fmt;
        end
      end else if (timeout_hit) begin
        state_d   = FB_LSU_IDLE;
        req_d     = 1'b0;
        bus_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FB_LSU_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      ctx_q      <= '0;
      cnt_q      <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      st_done_q  <= 1'b0;
      acc_err_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      ctx_q      <= ctx_d;
      cnt_q      <= cnt_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      st_done_q  <= st_done_d;
      acc_err_q  <= acc_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = ctx_q.we;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign st_done   = st_done_q;
  assign acc_err   = acc_err_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_fb_lsu.sv
module tb_fb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        lsu_stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ld_valid, st_done, acc_err, bus_err;
  logic [31:0] ld_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_ld = 32'h0;

  fb_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .lsu_stall(lsu_stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data), .st_done(st_done),
    .acc_err(acc_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Access size in bytes, 0 when the funct3 is not defined for that direction
  function automatic int m_size(input bit ld, input logic [2:0] f3);
    if (ld) begin
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      if (f3 == 3'd2) return 4;
      return 0;
    end
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return 2;
    if (f3 == 3'd2) return 4;
    return 0;
  endfunction

  // Expected load value: extract the addressed bytes, then extend
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int sz;
    longint unsigned mask, v;
    sz   = m_size(1'b1, f3);
    mask = (64'd1 << (8 * sz)) - 1;
    v    = (longint'(rd) >> (8 * (a % 4))) & mask;
    if (sz < 4 && f3[2] == 1'b0 && v >= (mask + 1) / 2) v = v | (~mask);
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = 3'd0; ex_addr = 32'h0; ex_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask

  // Starts and ends one time unit after a rising edge
  task automatic do_access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int dly);
    int sz, off, c, req_cycles;
    bit legal, done, tmo;
    logic [3:0]  strb;
    logic [31:0] lanes;
    sz    = m_size(ld, f3);
    off   = a % 4;
    legal = (sz != 0) && ((a % sz) == 0);
    strb  = 4'b0;
    lanes = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (legal && !ld && k >= off && k < off + sz) strb[k] = 1'b1;
      if (sz != 0) lanes[8*k +: 8] = wd[8*(k % sz) +: 8];
    end

    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = !ld;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd;
    @(negedge clk);
    chk("stall_at_present", lsu_stall, legal);
    chk("req_idle", mem_req, 1'b0);
    @(posedge clk); #1;

    if (!legal) begin
      chk("acc_err_pulse", acc_err, 1'b1);
      chk("err_no_req", mem_req, 1'b0);
      chk("err_no_ldv", ld_valid, 1'b0);
      ex_valid = 1'b0;
      @(negedge clk);
      chk("err_stall", lsu_stall, 1'b0);
      @(posedge clk); #1;
      chk("acc_err_clear", acc_err, 1'b0);
      chk("err_no_req2", mem_req, 1'b0);
      return;
    end

    chk("req_set", mem_req, 1'b1);
    chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
    chk("req_we", mem_we, !ld);
    chk("req_strb", mem_wstrb, strb);
    if (!ld) chk("req_wdata", mem_wdata, lanes);

    done = 0; tmo = 0; req_cycles = 0;
    for (c = 0; c < 64; c++) begin
      mem_ready = (c == dly);
      mem_rdata = mem_ready ? rd : $urandom;
      @(negedge clk);
      req_cycles++;
      chk("busy_req", mem_req, 1'b1);
      chk("busy_stall", lsu_stall, !mem_ready);
      done = mem_ready;
      tmo  = !mem_ready && (c == TO - 1);
      @(posedge clk); #1;
      if (done || tmo) break;
    end
    if (!(done || tmo)) chk("bus_bound", 32'd0, 32'd1);
    mem_ready = 1'b0;
    ex_valid  = 1'b0;

    chk("req_cycles", req_cycles, (dly >= TO) ? TO : dly + 1);
    chk("end_req", mem_req, 1'b0);
    chk("ld_valid", ld_valid, done && ld);
    chk("st_done", st_done, done && !ld);
    chk("bus_err", bus_err, tmo);
    chk("no_acc_err", acc_err, 1'b0);
    if (done && ld) last_ld = m_load(f3, a, rd);
    chk("ld_data", ld_data, last_ld);
    @(negedge clk);
    chk("after_stall", lsu_stall, 1'b0);
    @(posedge clk); #1;
    chk("pulse_ldv_clr", ld_valid, 1'b0);
    chk("pulse_st_clr", st_done, 1'b0);
    chk("pulse_be_clr", bus_err, 1'b0);
    chk("ld_data_hold", ld_data, last_ld);
  endtask

  initial begin
    bit ld;
    logic [2:0] f3;
    logic [31:0] a;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_strb", mem_wstrb, 4'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_ldv", ld_valid, 1'b0);
    chk("rst_ldd", ld_data, 32'h0);
    chk("rst_pulses", {st_done, acc_err, bus_err}, 3'b000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_access(1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    do_access(1, 3'b000, 32'h203, 32'h0, 32'h80FF_0000, 1);
    do_access(1, 3'b100, 32'h203, 32'h0, 32'h80FF_0000, 0);
    do_access(1, 3'b101, 32'h202, 32'h0, 32'h80FF_0000, 2);
    do_access(0, 3'b001, 32'h306, 32'h1234ABCD, 32'h0, 0);
    do_access(1, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    do_access(1, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    do_access(1, 3'b010, 32'h400, 32'h0, 32'h11112222, 9);
    do_access(0, 3'b000, 32'h401, 32'h000000A5, 32'h0, 9);
    do_access(1, 3'b001, 32'h402, 32'h0, 32'h8001_7FFF, TO - 1);

    // Reset during the second cycle of a transfer
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0;
    ex_funct3 = 3'b010; ex_addr = 32'h500;
    @(posedge clk); #1;
    chk("rstmid_req", mem_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_req_clr", mem_req, 1'b0);
    chk("rstmid_no_pulse", {ld_valid, st_done, bus_err}, 3'b000);
    rst = 1'b0;
    ex_valid = 1'b0;
    last_ld = 32'h0;
    @(posedge clk); #1;
    do_access(1, 3'b010, 32'h600, 32'h0, 32'hCAFE_F00D, 1);

    // Randomized accesses, biased towards legal and aligned
    for (int i = 0; i < 80; i++) begin
      ld = $urandom_range(0, 1);
      f3 = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) f3 = ld ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      do_access(ld, f3, a, $urandom, $urandom, $urandom_range(0, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
